task_dispatcher: RTL and testbench



---
 rtl/sph_pkg.sv | 29 ++
 rtl/task_fifo.sv | 41 ++++
 rtl/task_dispatcher.sv | 166 ++++++++++++++++
 tb/tb_task_dispatcher.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sph_pkg.sv
// Shared SPH task definitions: task kinds, payload field layout and dispatcher states.
package sph_pkg;

   typedef enum logic [1:0] {
      DENSITY = 2'd0,
      FORCE   = 2'd1
   } task_type_t;

   localparam int FIELD_W    = 16;
   localparam int NUM_FIELDS = 5;
   localparam int TASK_W     = FIELD_W * NUM_FIELDS;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } disp_state_t;

   // Payload order is [x_i, x_j, P_i, P_j, rho_j]; field 0 (x_i) sits in the top bits.
   function automatic int field_lsb(input int field_idx);
      return (NUM_FIELDS - 1 - field_idx) * FIELD_W;
   endfunction

   function automatic int wrap_add(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/task_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide in one cycle.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module task_fifo #(
   parameter int WIDTH = 82,
   parameter int DEPTH = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk_in) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

endmodule

// File: rtl/task_dispatcher.sv
// Buffers scheduler tasks and issues them round-robin to NUM_UNITS compute units, pulsing frame_done
// once the frame has drained. Define DISPATCH_STATS_EN to add stat_density/stat_force counters.
module task_dispatcher
   import sph_pkg::*;
#(
   parameter int NUM_UNITS  = 4,
   parameter int TASK_WIDTH = TASK_W,
   parameter int FIFO_DEPTH = 8,
   parameter int OUT_WIDTH  = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  frame_start,
   input  logic                  sched_done,
   input  logic                  valid_task,
   input  logic [1:0]            task_type,
   input  logic [TASK_WIDTH-1:0] task_data,
   output logic                  almost_full,
   output logic                  overflow_err,
   output logic [NUM_UNITS-1:0]  unit_valid,
   output logic [1:0]            unit_type,
   output logic [TASK_WIDTH-1:0] unit_data,
   input  logic [NUM_UNITS-1:0]  unit_ready,
   input  logic [NUM_UNITS-1:0]  unit_done,
`ifdef DISPATCH_STATS_EN
   output logic [31:0]           stat_density,
   output logic [31:0]           stat_force,
`endif
   output logic [1:0]            fsm_state,
   output logic                  frame_done
);

   localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int SUM_W = OUT_WIDTH + 2;

   disp_state_t             state;
   logic [PTR_W-1:0]        rr_ptr;
   logic [OUT_WIDTH-1:0]    outstanding;
   logic [OUT_WIDTH-1:0]    out_next;
   logic [CNT_W-1:0]        fifo_count;
   logic [1:0]              head_type;
   logic [TASK_WIDTH-1:0]   head_data;
   logic [NUM_UNITS-1:0]    grant_oh;
   logic [PTR_W-1:0]        grant_idx;
   logic [PTR_W-1:0]        scan_idx;
   logic                    grant_found;
   logic [SUM_W-1:0]        up_sum;
   logic [SUM_W-1:0]        dn_sum;

   // Handshake: a unit takes the task in any cycle where its unit_valid bit and unit_ready are both
   // high; until then unit_valid/unit_type/unit_data hold steady regardless of unit_ready.
   logic accepting, accept, out_full, load, push, drop, start_frame, drained;

   assign accepting   = (state == ST_RUN) || (state == ST_DRAIN);
   assign out_full    = |unit_valid;
   assign accept      = |(unit_valid & unit_ready);
   assign load        = (!out_full || accept) && (fifo_count != '0) && grant_found;
   assign push        = accepting && valid_task && ((fifo_count < CNT_W'(FIFO_DEPTH)) || load);
   assign drop        = accepting && valid_task && !push;
   assign start_frame = (state == ST_IDLE) && frame_start;
   assign drained     = (fifo_count == '0) && !out_full && (outstanding == '0);
   assign almost_full = (fifo_count >= CNT_W'(FIFO_DEPTH - 2));
   assign fsm_state   = state;

   task_fifo #(
      .WIDTH (TASK_WIDTH + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .push     (push),
      .wr_data  ({task_type, task_data}),
      .pop      (load),
      .rd_data  ({head_type, head_data}),
      .count    (fifo_count)
   );

   // First ready unit at or after rr_ptr, wrapping at NUM_UNITS.
   always_comb begin
      grant_oh    = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      scan_idx    = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         scan_idx = PTR_W'(wrap_add(int'(rr_ptr), i, NUM_UNITS));
         if (!grant_found && unit_ready[scan_idx]) begin
            grant_found        = 1'b1;
            grant_idx          = scan_idx;
            grant_oh[scan_idx] = 1'b1;
         end
      end
   end

   // Net change is applied first, then clamped to [0, 2^OUT_WIDTH-1].
   always_comb begin
      up_sum = {2'b00, outstanding} + SUM_W'(accept);
      dn_sum = SUM_W'($countones(unit_done));
      if (dn_sum >= up_sum)
         out_next = '0;
      else if ((up_sum - dn_sum) > {2'b00, {OUT_WIDTH{1'b1}}})
         out_next = '1;
      else
         out_next = OUT_WIDTH'(up_sum - dn_sum);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state        <= ST_IDLE;
         frame_done   <= 1'b0;
         overflow_err <= 1'b0;
         outstanding  <= '0;
         rr_ptr       <= '0;
         unit_valid   <= '0;
         unit_type    <= '0;
         unit_data    <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE:  if (frame_start) state <= ST_RUN;
            ST_RUN:   if (sched_done) state <= ST_DRAIN;
            ST_DRAIN: if (drained) begin
               state      <= ST_DONE;
               frame_done <= 1'b1;
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase

         if (start_frame) begin
            overflow_err <= 1'b0;
            outstanding  <= '0;
         end else begin
            if (drop) overflow_err <= 1'b1;
            outstanding <= out_next;
         end

         if (load) begin
            unit_valid <= grant_oh;
            unit_type  <= head_type;
            unit_data  <= head_data;
            rr_ptr     <= PTR_W'(wrap_add(int'(grant_idx), 1, NUM_UNITS));
         end else if (accept) begin
            unit_valid <= '0;
         end
      end
   end

`ifdef DISPATCH_STATS_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stat_density <= '0;
         stat_force   <= '0;
      end else if (start_frame) begin
         stat_density <= '0;
         stat_force   <= '0;
      end else if (accept) begin
         if (task_type_t'(unit_type) == FORCE)
            stat_force <= stat_force + 32'd1;
         else if (task_type_t'(unit_type) == DENSITY)
            stat_density <= stat_density + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: a queue-based frame model checked every cycle, plus
// hand-computed expectations for rotation, stalls, overflow, drain timing and mid-frame reset.
module tb_task_dispatcher;

   localparam int NU    = 4;
   localparam int TW    = 80;
   localparam int DEPTH = 8;
   localparam int W     = TW + 2;

   logic          clk_in = 1'b0;
   logic          rst_n_in;
   logic          frame_start;
   logic          sched_done;
   logic          valid_task;
   logic [1:0]    task_type;
   logic [TW-1:0] task_data;
   logic          almost_full;
   logic          overflow_err;
   logic [NU-1:0] unit_valid;
   logic [1:0]    unit_type;
   logic [TW-1:0] unit_data;
   logic [NU-1:0] unit_ready;
   logic [NU-1:0] unit_done;
   logic [1:0]    fsm_state;
   logic          frame_done;
`ifdef DISPATCH_STATS_EN
   logic [31:0]   stat_density;
   logic [31:0]   stat_force;
`endif

   task_dispatcher #(
      .NUM_UNITS  (NU),
      .TASK_WIDTH (TW),
      .FIFO_DEPTH (DEPTH),
      .OUT_WIDTH  (8)
   ) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .frame_start  (frame_start),
      .sched_done   (sched_done),
      .valid_task   (valid_task),
      .task_type    (task_type),
      .task_data    (task_data),
      .almost_full  (almost_full),
      .overflow_err (overflow_err),
      .unit_valid   (unit_valid),
      .unit_type    (unit_type),
      .unit_data    (unit_data),
      .unit_ready   (unit_ready),
      .unit_done    (unit_done),
`ifdef DISPATCH_STATS_EN
      .stat_density (stat_density),
      .stat_force   (stat_force),
`endif
      .fsm_state    (fsm_state),
      .frame_done   (frame_done)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic auto_done = 1'b0;
   logic [NU-1:0] done_plan [0:4095];
   int grant_log[$];
   int acc_cyc[$];
   int fd_count = 0;
   int fd_cyc   = -1;
   int done_cyc = -1;

   // Frame model: expected queue of buffered tasks, one issue slot, pointer, in-flight count, phase.
   logic [W-1:0] exp_q[$];
   logic         m_v;
   int           m_u;
   logic [W-1:0] m_task;
   int           m_rr;
   int           m_out;
   logic         m_ov;
   logic         m_fd;
   int           m_phase;   // 0 idle, 1 run, 2 drain, 3 done

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [TW-1:0] make_data(input int id);
      logic [15:0] v;
      v = 16'(id);
      return {v, ~v, v ^ 16'hA5A5, v + 16'h0100, 16'hBEEF - v};
   endfunction

   always @(negedge clk_in) begin : model
      logic          acc;
      logic          loaded;
      logic          drained;
      logic [NU-1:0] exp_valid;
      int            sz;
      int            k;
      int            nxt;
      int            acc_u;
      if (!rst_n_in) begin
         exp_q.delete();
         m_v = 1'b0; m_u = 0; m_task = '0; m_rr = 0; m_out = 0;
         m_ov = 1'b0; m_fd = 1'b0; m_phase = 0;
      end else begin
         exp_valid = '0;
         if (m_v) exp_valid[m_u] = 1'b1;
         check("unit_valid", unit_valid, exp_valid);
         if (m_v) begin
            check("unit_data", unit_data, m_task[TW-1:0]);
            check("unit_type", unit_type, m_task[W-1:TW]);
         end
         check("almost_full", almost_full, exp_q.size() >= DEPTH - 2);
         check("overflow_err", overflow_err, m_ov);
         check("frame_done", frame_done, m_fd);

         if (frame_done) begin fd_count++; fd_cyc = cyc; end
         if (unit_done != '0) done_cyc = cyc;
         if ((unit_valid & unit_ready) != '0) begin
            for (int i = 0; i < NU; i++) if (unit_valid[i]) grant_log.push_back(i);
            acc_cyc.push_back(cyc);
         end

         acc     = m_v && unit_ready[m_u];
         acc_u   = m_u;
         drained = (exp_q.size() == 0) && !m_v && (m_out == 0);
         sz      = exp_q.size();
         loaded  = 1'b0;
         if ((!m_v || acc) && sz > 0 && unit_ready != '0) begin
            k = -1;
            for (int i = 0; i < NU; i++)
               if (k < 0 && unit_ready[(m_rr + i) % NU]) k = (m_rr + i) % NU;
            m_task = exp_q.pop_front();
            m_v = 1'b1; m_u = k; m_rr = (k + 1) % NU; loaded = 1'b1;
         end else if (acc) begin
            m_v = 1'b0;
         end
         if (acc && auto_done) done_plan[(cyc + 3) % 4096][acc_u] = 1'b1;
         if ((m_phase == 1 || m_phase == 2) && valid_task) begin
            if (sz < DEPTH || loaded) exp_q.push_back({task_type, task_data});
            else m_ov = 1'b1;
         end

         m_fd = 1'b0;
         if (m_phase == 0 && frame_start) begin
            m_phase = 1; m_out = 0; m_ov = 1'b0;
         end else begin
            nxt   = m_out + (acc ? 1 : 0) - $countones(unit_done);
            m_out = (nxt < 0) ? 0 : ((nxt > 255) ? 255 : nxt);
            if (m_phase == 1 && sched_done) m_phase = 2;
            else if (m_phase == 2 && drained) begin m_phase = 3; m_fd = 1'b1; end
            else if (m_phase == 3) m_phase = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
      valid_task  = 1'b0;
      frame_start = 1'b0;
      unit_done   = done_plan[cyc % 4096];
      done_plan[cyc % 4096] = '0;
   endtask

   task automatic push_task(input int id);
      valid_task = 1'b1;
      task_type  = 2'(id & 1);
      task_data  = make_data(id);
      tick();
   endtask

   task automatic wait_frame(input string name);
      int start;
      int n;
      start = fd_count;
      n = 0;
      while (fd_count == start && n < 200) begin tick(); n++; end
      check({name, "_frame_done_seen"}, fd_count - start, 1);
      repeat (4) tick();
      check({name, "_frame_done_once"}, fd_count - start, 1);
      sched_done = 1'b0;
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int base;
      rst_n_in = 1'b0; frame_start = 1'b0; sched_done = 1'b0; valid_task = 1'b0;
      task_type = '0; task_data = '0; unit_ready = '0; unit_done = '0;
      for (int i = 0; i < 4096; i++) done_plan[i] = '0;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_unit_valid", unit_valid, 4'b0000);
      check("rst_unit_data", unit_data, 80'h0);
      check("rst_overflow", overflow_err, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_almost_full", almost_full, 1'b0);
      check("rst_fsm_state", fsm_state, 2'd0);
      rst_n_in = 1'b1;
      tick();

      // 16 tasks, all units ready, each done 3 cycles after its accept.
      unit_ready = 4'b1111; auto_done = 1'b1;
      frame_start = 1'b1; tick();
      base = grant_log.size();
      for (int i = 0; i < 16; i++) push_task(i);
      sched_done = 1'b1;
      wait_frame("t1");
      check("t1_accepts", grant_log.size() - base, 16);
      for (int i = 0; i < 16 && base + i < grant_log.size(); i++)
         check("t1_grant", grant_log[base + i], i % 4);
      check("t1_done_to_frame_done", fd_cyc - done_cyc, 2);

      // Only unit 2 ready: three back-to-back issues, then pointer sits at 3.
      frame_start = 1'b1; tick();
      unit_ready = 4'b0100;
      base = grant_log.size();
      for (int i = 0; i < 3; i++) push_task(20 + i);
      repeat (4) tick();
      check("t2_accepts", grant_log.size() - base, 3);
      for (int i = 0; i < 3 && base + i < grant_log.size(); i++)
         check("t2_grant", grant_log[base + i], 2);
      if (base + 2 < acc_cyc.size()) begin
         check("t2_b2b_a", acc_cyc[base + 1] - acc_cyc[base], 1);
         check("t2_b2b_b", acc_cyc[base + 2] - acc_cyc[base + 1], 1);
      end
      unit_ready = 4'b1111;
      push_task(30);
      repeat (3) tick();
      check("t2_next_grant", grant_log[grant_log.size() - 1], 3);
      sched_done = 1'b1;
      wait_frame("t2");

      // Ready withdrawn while unit 1 holds a task.
      frame_start = 1'b1; tick();
      unit_ready = 4'b0010;
      push_task(100);
      tick();
      unit_ready = 4'b0000;
      check("t3_issued_valid", unit_valid, 4'b0010);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_hold_valid", unit_valid, 4'b0010);
         check("t3_hold_data", unit_data, make_data(100));
      end
      base = grant_log.size();
      unit_ready = 4'b0010;
      tick();
      check("t3_cleared", unit_valid, 4'b0000);
      tick();
      check("t3_single_accept", grant_log.size() - base, 1);
      check("t3_accept_unit", grant_log[grant_log.size() - 1], 1);
      sched_done = 1'b1;
      wait_frame("t3");

      // All units stalled, ten pushes into an eight-entry buffer.
      frame_start = 1'b1; tick();
      unit_ready = 4'b0000;
      for (int k = 1; k <= 10; k++) begin
         push_task(200 + k);
         if (k == 5) check("t4_af_at5", almost_full, 1'b0);
         if (k == 6) check("t4_af_at6", almost_full, 1'b1);
         if (k == 8) check("t4_ov_at8", overflow_err, 1'b0);
         if (k == 9) check("t4_ov_at9", overflow_err, 1'b1);
      end
      base = grant_log.size();
      unit_ready = 4'b1111;
      repeat (14) tick();
      check("t4_accepts", grant_log.size() - base, 8);
      sched_done = 1'b1;
      wait_frame("t4");
      check("t4_ov_sticky", overflow_err, 1'b1);

      // Two in flight on units 2 and 3, both done in one cycle.
      frame_start = 1'b1; tick();
      check("t5_ov_cleared", overflow_err, 1'b0);
      auto_done = 1'b0;
      push_task(300);
      push_task(301);
      repeat (3) tick();
      check("t5_grant_a", grant_log[grant_log.size() - 2], 2);
      check("t5_grant_b", grant_log[grant_log.size() - 1], 3);
      sched_done = 1'b1;
      repeat (3) tick();
      check("t5_fd_wait", frame_done, 1'b0);
      unit_done = 4'b1100;
      tick();
      check("t5_fd_after_done", frame_done, 1'b0);
      tick();
      check("t5_fd_pulse", frame_done, 1'b1);
      tick();
      check("t5_fd_end", frame_done, 1'b0);
      sched_done = 1'b0;

      // Asynchronous reset with five tasks buffered and one held at unit 0.
      frame_start = 1'b1; tick();
      unit_ready = 4'b0000;
      for (int i = 0; i < 5; i++) push_task(500 + i);
      unit_ready = 4'b0001;
      tick();
      unit_ready = 4'b0000;
      push_task(505);
      check("t6_pre_valid", unit_valid, 4'b0001);
      #2;
      rst_n_in = 1'b0;
      #1;
      check("t6_rst_valid", unit_valid, 4'b0000);
      check("t6_rst_data", unit_data, 80'h0);
      check("t6_rst_type", unit_type, 2'd0);
      check("t6_rst_af", almost_full, 1'b0);
      check("t6_rst_fd", frame_done, 1'b0);
      tick();
      tick();
      rst_n_in = 1'b1;
      tick();
      unit_ready = 4'b1111; auto_done = 1'b1;
      frame_start = 1'b1; tick();
      base = grant_log.size();
      for (int i = 0; i < 3; i++) push_task(600 + i);
      sched_done = 1'b1;
      wait_frame("t6");
      check("t6_accepts", grant_log.size() - base, 3);
      for (int i = 0; i < 3 && base + i < grant_log.size(); i++)
         check("t6_grant", grant_log[base + i], i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
